// File: rtl/tl45_decode.sv
// tl45_decode -- decode / operand-fetch stage of the tl45 pipeline.
//
// Decodes an LC-2200-style instruction and reads the register file. Each source
// operand is resolved through the ALU-stage and memory-stage forward paths.
// Load-use hazards against the LW held in the output buffer are detected here.
// The stage registers everything the ALU stage consumes.
//
// Ports:
//   i_clk, i_reset_n             clock (rising), async active-low reset
//   i_pipe_stall / i_pipe_flush  from ALU stage: hold / clear output buffer
//   o_pipe_stall / o_pipe_flush  to fetch stage
//   i_pc, i_instr                fetched instruction (all-zero = bubble)
//   o_rf_sr1/2, i_rf_sr1/2_val   combinational register-file read port
//   i_of1_reg/val, i_of2_reg/val ALU-stage / memory-stage forward (reg 0 = none)
//   o_pc .. o_target_address     registered decode result (1-cycle latency)
module tl45_decode (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_stall,
    output logic        o_pipe_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [3:0]  o_rf_sr1,
    output logic [3:0]  o_rf_sr2,
    input  logic [31:0] i_rf_sr1_val,
    input  logic [31:0] i_rf_sr2_val,
    input  logic [3:0]  i_of1_reg,
    input  logic [31:0] i_of1_val,
    input  logic [3:0]  i_of2_reg,
    input  logic [31:0] i_of2_val,
    output logic [31:0] o_pc,
    output logic [3:0]  o_opcode,
    output logic [3:0]  o_dr,
    output logic        o_skp_mode,
    output logic [31:0] o_sr1_val,
    output logic [31:0] o_sr2_val,
    output logic [31:0] o_target_address
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_SW   = 4'd4;
    localparam logic [3:0] OP_GOTO = 4'd5;
    localparam logic [3:0] OP_JALR = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;
    localparam logic [3:0] OP_SKP  = 4'd8;
    localparam logic [3:0] OP_LEA  = 4'd9;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  opcode;
        logic [3:0]  dr;
        logic        skp_mode;
        logic [31:0] sr1;
        logic [31:0] sr2;
        logic [31:0] tgt;
    } dec_t;

    dec_t        q, nxt;
    logic [3:0]  op, rx, ry, rz;
    logic [31:0] off;
    logic [3:0]  sr1_reg, sr2_reg;
    logic [31:0] sr1_v, sr2_v;
    logic        valid;
    logic        hazard;

    assign op  = i_instr[31:28];
    assign rx  = i_instr[27:24];
    assign ry  = i_instr[23:20];
    assign rz  = i_instr[3:0];
    assign off = {{12{i_instr[19]}}, i_instr[19:0]};

    // R0 reads as zero; the ALU forward is younger, so it beats the memory forward.
    function automatic logic [31:0] resolve(input logic [3:0] r, input logic [31:0] rf_val);
        if (r == 4'd0)           return 32'd0;
        else if (r == i_of1_reg) return i_of1_val;
        else if (r == i_of2_reg) return i_of2_val;
        else                     return rf_val;
    endfunction

    always_comb begin
        nxt     = '0;
        sr1_reg = '0;
        sr2_reg = '0;
        valid   = (i_instr != 32'd0);
        unique case (op)
            OP_ADD, OP_NAND: begin nxt.dr = rx; sr1_reg = ry; sr2_reg = rz; end
            OP_ADDI, OP_LW:  begin nxt.dr = rx; sr1_reg = ry; end
            OP_SW:           begin sr1_reg = ry; sr2_reg = rx; end
            OP_GOTO, OP_HALT: ;
            OP_LEA:          nxt.dr = rx;
            OP_JALR:         begin nxt.dr = ry; sr1_reg = rx; end
            OP_SKP:          begin sr1_reg = rx; sr2_reg = ry; nxt.skp_mode = i_instr[0]; end
            default:         valid = 1'b0;
        endcase
        // Unused/bubble slots read R0 so they can never match a pending LW.
        if (!valid) begin
            sr1_reg = '0;
            sr2_reg = '0;
        end
        sr1_v = resolve(sr1_reg, i_rf_sr1_val);
        sr2_v = resolve(sr2_reg, i_rf_sr2_val);

        nxt.pc     = i_pc + 32'd1;
        nxt.opcode = op;
        nxt.sr1    = sr1_v;
        nxt.sr2    = (op == OP_ADDI || op == OP_LW) ? off : sr2_v;
        case (op)
            OP_LW, OP_SW:    nxt.tgt = sr1_v + off;
            OP_GOTO, OP_LEA: nxt.tgt = i_pc + 32'd1 + off;
            OP_SKP:          nxt.tgt = i_pc + 32'd2;
            default:         nxt.tgt = 32'd0;
        endcase
        if (!valid) nxt = '0;
    end

    // Immediates never reach sr*_reg, so only true register reads can collide.
    assign hazard = (q.opcode == OP_LW) && (q.dr != 4'd0) &&
                    ((sr1_reg == q.dr) || (sr2_reg == q.dr));

    assign o_pipe_stall = i_pipe_stall | (hazard & ~i_pipe_flush);
    assign o_pipe_flush = i_pipe_flush;
    assign o_rf_sr1     = sr1_reg;
    assign o_rf_sr2     = sr2_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)        q <= '0;
        else if (i_pipe_flush) q <= '0;
        else if (i_pipe_stall) q <= q;
        else if (hazard)       q <= '0;
        else                   q <= nxt;
    end

    assign o_pc             = q.pc;
    assign o_opcode         = q.opcode;
    assign o_dr             = q.dr;
    assign o_skp_mode       = q.skp_mode;
    assign o_sr1_val        = q.sr1;
    assign o_sr2_val        = q.sr2;
    assign o_target_address = q.tgt;

endmodule

// File: tb/tb_tl45_decode.sv
module tb_tl45_decode;

    logic        i_clk = 1'b0;
    logic        i_reset_n, i_pipe_stall, i_pipe_flush;
    logic        o_pipe_stall, o_pipe_flush;
    logic [31:0] i_pc, i_instr;
    logic [3:0]  o_rf_sr1, o_rf_sr2;
    logic [31:0] i_rf_sr1_val, i_rf_sr2_val;
    logic [3:0]  i_of1_reg, i_of2_reg;
    logic [31:0] i_of1_val, i_of2_val;
    logic [31:0] o_pc;
    logic [3:0]  o_opcode, o_dr;
    logic        o_skp_mode;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_address;

    logic [31:0] rf [16];
    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_rf_sr1_val = rf[o_rf_sr1];
        i_rf_sr2_val = rf[o_rf_sr2];
    end

    tl45_decode dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
        .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
        .i_pc(i_pc), .i_instr(i_instr),
        .o_rf_sr1(o_rf_sr1), .o_rf_sr2(o_rf_sr2),
        .i_rf_sr1_val(i_rf_sr1_val), .i_rf_sr2_val(i_rf_sr2_val),
        .i_of1_reg(i_of1_reg), .i_of1_val(i_of1_val),
        .i_of2_reg(i_of2_reg), .i_of2_val(i_of2_val),
        .o_pc(o_pc), .o_opcode(o_opcode), .o_dr(o_dr), .o_skp_mode(o_skp_mode),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
        .o_target_address(o_target_address)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        i_reset_n = 1'b0; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
        i_of1_reg = 4'd0; i_of1_val = 32'd0; i_of2_reg = 4'd0; i_of2_val = 32'd0;
        i_pc = 32'h100; i_instr = 32'h2100_0005;   // ADDI R1,R0,5

        // reset held across edges
        step(); step();
        chk("rst_opcode", {28'd0, o_opcode}, 32'd0);
        chk("rst_dr",     {28'd0, o_dr},     32'd0);
        chk("rst_sr2",    o_sr2_val,         32'd0);
        chk("rst_pc",     o_pc,              32'd0);
        chk("rst_stall",  {31'd0, o_pipe_stall}, 32'd0);
        i_reset_n = 1'b1;
        step();
        chk("addi_opcode", {28'd0, o_opcode}, 32'd2);
        chk("addi_dr",     {28'd0, o_dr},     32'd1);
        chk("addi_sr1",    o_sr1_val,         32'd0);
        chk("addi_sr2",    o_sr2_val,         32'd5);
        chk("addi_pc",     o_pc,              32'h101);

        // forwarding priority: ADD R3,R1,R2
        rf[1] = 32'd7; rf[2] = 32'd9;
        i_instr = 32'h0310_0002;
        i_of1_reg = 4'd2; i_of1_val = 32'd100;
        i_of2_reg = 4'd2; i_of2_val = 32'd50;
        #1;
        chk("add_rfaddr1", {28'd0, o_rf_sr1}, 32'd1);
        chk("add_rfaddr2", {28'd0, o_rf_sr2}, 32'd2);
        step();
        chk("add_sr1",    o_sr1_val, 32'd7);
        chk("add_sr2_of1", o_sr2_val, 32'd100);
        chk("add_dr",     {28'd0, o_dr}, 32'd3);
        i_of1_reg = 4'd0;
        step();
        chk("add_sr2_of2", o_sr2_val, 32'd50);
        i_of2_reg = 4'd0;

        // load-use: LW R4,0(R5) then ADD R6,R4,R4
        rf[5] = 32'h200;
        i_instr = 32'h3450_0000;
        step();
        chk("lw_opcode", {28'd0, o_opcode}, 32'd3);
        chk("lw_tgt",    o_target_address,  32'h200);
        i_instr = 32'h0640_0004;
        #1;
        chk("hz_stall", {31'd0, o_pipe_stall}, 32'd1);
        step();
        chk("hz_bubble_op",  {28'd0, o_opcode}, 32'd0);
        chk("hz_bubble_dr",  {28'd0, o_dr},     32'd0);
        chk("hz_bubble_pc",  o_pc,              32'd0);
        chk("hz_bubble_tgt", o_target_address,  32'd0);
        i_of2_reg = 4'd4; i_of2_val = 32'h1234;
        #1;
        chk("hz_release", {31'd0, o_pipe_stall}, 32'd0);
        step();
        chk("use_sr1", o_sr1_val, 32'h1234);
        chk("use_sr2", o_sr2_val, 32'h1234);
        chk("use_dr",  {28'd0, o_dr}, 32'd6);
        i_instr = 32'h0740_0004;                  // second use: no extra bubble
        #1;
        chk("use2_nostall", {31'd0, o_pipe_stall}, 32'd0);
        step();
        chk("use2_sr1", o_sr1_val, 32'h1234);
        i_of2_reg = 4'd0;

        // GOTO off=-3 at pc 0x10
        i_pc = 32'h10; i_instr = 32'h500F_FFFD;
        step();
        chk("goto_tgt", o_target_address, 32'h0E);
        chk("goto_dr",  {28'd0, o_dr},    32'd0);
        chk("goto_pc",  o_pc,             32'h11);
        // SKP R1,R2 mode LT at pc 0x20
        i_pc = 32'h20; i_instr = 32'h8120_0001;
        step();
        chk("skp_mode", {31'd0, o_skp_mode}, 32'd1);
        chk("skp_tgt",  o_target_address,    32'h22);
        chk("skp_sr1",  o_sr1_val,           32'd7);
        chk("skp_sr2",  o_sr2_val,           32'd9);
        // opcode 12 decodes as a bubble
        i_instr = 32'hC123_4567;
        step();
        chk("op12_opcode", {28'd0, o_opcode}, 32'd0);
        chk("op12_pc",     o_pc,              32'd0);
        // LEA R5,4 at pc 0x30
        i_pc = 32'h30; i_instr = 32'h9500_0004;
        step();
        chk("lea_dr",  {28'd0, o_dr},    32'd5);
        chk("lea_tgt", o_target_address, 32'h35);

        // downstream stall holds the buffer for 3 cycles
        i_pipe_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_instr = 32'h0310_0002 + c;
            i_pc    = 32'h40 + c;
            #1;
            chk("stall_out", {31'd0, o_pipe_stall}, 32'd1);
            step();
            chk("stall_hold_dr",  {28'd0, o_dr},    32'd5);
            chk("stall_hold_tgt", o_target_address, 32'h35);
        end
        i_pipe_stall = 1'b0;

        // flush beats a simultaneous hazard and stall
        i_instr = 32'h3450_0000;
        step();
        i_instr = 32'h0640_0004;
        i_pipe_flush = 1'b1;
        #1;
        chk("flush_hz_nostall", {31'd0, o_pipe_stall}, 32'd0);
        i_pipe_stall = 1'b1;
        #1;
        chk("flush_stall", {31'd0, o_pipe_stall}, 32'd1);
        chk("flush_out",   {31'd0, o_pipe_flush}, 32'd1);
        step();
        chk("flush_opcode", {28'd0, o_opcode}, 32'd0);
        chk("flush_dr",     {28'd0, o_dr},     32'd0);
        chk("flush_tgt",    o_target_address,  32'd0);
        i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;

        // async reset mid-cycle clears the buffer without an edge
        i_pc = 32'h50; i_instr = 32'h2100_0005;
        step();
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_pc", o_pc, 32'd0);
        chk("arst_dr", {28'd0, o_dr}, 32'd0);
        i_reset_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl45_decode.md
# tl45_decode

Decode/operand-fetch stage of the tl45 pipeline, directly upstream of the ALU stage. It takes a fetched instruction and its PC, decodes the LC-2200-style encoding, reads the register file, resolves operands through the ALU and memory-stage forwarding paths, detects load-use hazards, and registers the opcode, destination, operand values, skip mode and target address that the ALU stage consumes. It propagates stall upstream and honours flush from the ALU stage.

## Interface
Parameters: none.
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_pipe_stall  in  1  downstream stall; hold output buffer
- i_pipe_flush  in  1  downstream flush; clear output buffer
- o_pipe_stall  out  1  stall to fetch stage
- o_pipe_flush  out  1  flush to fetch stage (= i_pipe_flush)
- i_pc  in  32  address of i_instr
- i_instr  in  32  instruction; all-zero is a bubble
- o_rf_sr1, o_rf_sr2  out  4  combinational register-file read addresses
- i_rf_sr1_val, i_rf_sr2_val  in  32  combinational register-file read data
- i_of1_reg, i_of1_val  in  4/32  ALU-stage forward (reg 0 = none)
- i_of2_reg, i_of2_val  in  4/32  memory-stage forward (reg 0 = none)
- o_pc  out  32  registered i_pc + 1
- o_opcode  out  4  registered opcode
- o_dr  out  4  registered destination (0 = no write)
- o_skp_mode  out  1  0 SKPEQ, 1 SKPLT
- o_sr1_val, o_sr2_val  out  32  registered resolved operands
- o_target_address  out  32  registered target / effective address

## Operation
- Fields: op=[31:28], RX=[27:24], RY=[23:20], RZ=[3:0], off=signext([19:0]) to 32 bits. Opcodes: ADD 0, NAND 1, ADDI 2, LW 3, SW 4, GOTO 5, JALR 6, HALT 7, SKP 8, LEA 9; 10-15 decode as bubble.
- Per opcode (dr / sr1 / sr2 / target):
  - ADD, NAND: RX / R[RY] / R[RZ] / 0
  - ADDI: RX / R[RY] / off / 0
  - LW: RX / R[RY] / off / R[RY]+off
  - SW: 0 / R[RY] / R[RX] (store data) / R[RY]+off
  - GOTO, LEA: 0 (GOTO), RX (LEA) / 0 / 0 / i_pc+1+off
  - JALR: RY / R[RX] / 0 / 0
  - SKP: 0 / R[RX] / R[RY] / i_pc+2; skp_mode=i_instr[0]
  - HALT: 0 / 0 / 0 / 0
- Operand resolution per source register r: r==0 gives 0; else i_of1 match; else i_of2 match; else register file. ALU forward wins over memory forward.
- All adds are 32-bit modulo, carry discarded.
- Load-use hazard: the output buffer holds LW with o_dr!=0, and the current instruction reads o_dr as a register source (not through the immediate). On a hazard, assert o_pipe_stall, load a bubble (all outputs 0) into the buffer, and keep i_instr upstream. The next cycle re-decodes with the LW value available on i_of2.
- Priority at each edge:
  - flush clears the buffer.
  - else downstream stall holds the buffer.
  - else hazard inserts a bubble.
  - else decode and load.
- o_pipe_stall = i_pipe_stall | (hazard & ~i_pipe_flush).

## Timing
- Reset (async, any time): every registered output is 0. o_pipe_stall and o_pipe_flush follow their combinational equations.
- Latency 1 cycle: instruction at edge N appears on outputs after edge N.
- A bubble is exactly the all-zero buffer (ADD, dr 0), which the ALU treats as a no-op.
- Reset released mid-hazard: the buffer is empty, so there is no hazard on the first cycle.
- Flush with a simultaneous hazard or stall: the buffer is cleared and o_pipe_stall = i_pipe_stall only.
- Consecutive LW→use→use: one bubble only; the second use is forwarded from memory or the register file.
- Forwarding and register-file paths are combinational within the cycle. No combinational path from i_instr to o_pipe_flush.

## Test plan
- Reset with instr ADDI R1,R0,5 held: all outputs 0 while i_reset_n=0. After release, one edge later: o_opcode=2, o_dr=1, o_sr1_val=0, o_sr2_val=5.
- ADD R3,R1,R2 with RF R1=7, R2=9, i_of1_reg=2/val=100, i_of2_reg=2/val=50 → o_sr1_val=7, o_sr2_val=100 (ALU wins). With i_of1_reg=0 → 50.
- LW R4,0(R5) then ADD R6,R4,R4:
  - cycle after the LW: o_pipe_stall=1 and the buffer becomes a bubble.
  - next cycle, with i_of2_reg=4/val=0x1234: ADD issues with both operands 0x1234 and o_pipe_stall=0.
- GOTO off=-3 at i_pc=0x10 → o_target_address=0x0E, o_dr=0. SKP instr[0]=1 at pc 0x20 → o_skp_mode=1, target 0x22.
- i_pipe_stall=1 for 3 cycles while i_instr changes: outputs stay unchanged and o_pipe_stall=1.
- i_pipe_flush=1 with hazard and stall both active: buffer zero next edge, o_pipe_flush=1.
